led_activity_ctrl: RTL

LED_ACTIVITY_CTRL -- requirements
Module: led_activity_ctrl

---
 rtl/led_ctrl_pkg.sv | 20 ++
 rtl/sync2.sv | 25 ++
 rtl/led_activity_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED activity controller: state encoding and
// helpers that map a state to its LED/blink indication.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        StOff      = 2'd0,
        StSolid    = 2'd1,
        StBlinkOff = 2'd2,
        StBlinkOn  = 2'd3
    } led_state_e;

    function automatic logic state_lit(led_state_e s);
        return (s == StSolid) || (s == StBlinkOn);
    endfunction

    function automatic logic state_blinking(led_state_e s);
        return (s == StBlinkOff) || (s == StBlinkOn);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single level signal; asynchronous active-high
// reset clears both stages.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/led_activity_ctrl.sv
// Link/activity LED driver: solid when link is up, fixed-period blinking on
// activity, with lamp test override and selectable drive polarity.
module led_activity_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE    = 62500,
    parameter int unsigned BLINK_TICKS = 40,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic link,
    input  logic act,
    input  logic lamp_test,
    output logic led,
    output logic blinking
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PhW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);
    localparam logic [PhW-1:0] PhLast = PhW'(BLINK_TICKS - 1);

    logic link_s, act_s, lt_s;

    sync2 u_sync_link (.clk(clk), .rst(rst), .d_i(link),      .q_o(link_s));
    sync2 u_sync_act  (.clk(clk), .rst(rst), .d_i(act),       .q_o(act_s));
    sync2 u_sync_lt   (.clk(clk), .rst(rst), .d_i(lamp_test), .q_o(lt_s));

    led_state_e     state_q, state_d;
    logic [PsW-1:0] ps_q, ps_d;
    logic [PhW-1:0] ph_q, ph_d;
    logic           pend_q, pend_d;
    logic           led_q, led_d;
    logic           blinking_q, blinking_d;

    logic tick, phase_end, want_blink, restart;

    always_comb begin
        tick       = (ps_q == PsLast);
        phase_end  = tick && (ph_q == PhLast);
        want_blink = act_s | pend_q;

        state_d = state_q;
        case (state_q)
            StOff:      if (link_s) state_d = StSolid;
            StSolid:    if (want_blink) state_d = StBlinkOff;
            StBlinkOff: if (phase_end) state_d = StBlinkOn;
            StBlinkOn:  if (phase_end) state_d = want_blink ? StBlinkOff : StSolid;
            default:    state_d = StOff;
        endcase
        if (!link_s) state_d = StOff;

        // Restarting the time base makes every blink half-period full length.
        restart = (state_d == StOff) || (state_q == StSolid && state_d == StBlinkOff);

        ps_d = tick ? '0 : ps_q + 1'b1;
        ph_d = ph_q;
        if (tick) ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
        if (restart) begin
            ps_d = '0;
            ph_d = '0;
        end

        // Activity seen mid-period is remembered so another period follows.
        pend_d = pend_q;
        if (state_blinking(state_q) && act_s) pend_d = 1'b1;
        if (state_q == StBlinkOn && phase_end) pend_d = 1'b0;
        if (state_d == StOff) pend_d = 1'b0;

        led_d      = (state_lit(state_d) | lt_s) ^ ACTIVE_LOW;
        blinking_d = state_blinking(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StOff;
            ps_q       <= '0;
            ph_q       <= '0;
            pend_q     <= 1'b0;
            led_q      <= ACTIVE_LOW;
            blinking_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ps_q       <= ps_d;
            ph_q       <= ph_d;
            pend_q     <= pend_d;
            led_q      <= led_d;
            blinking_q <= blinking_d;
        end
    end

    assign led      = led_q;
    assign blinking = blinking_q;

endmodule
